// File: rtl/cpu_datapath_p.sv
// ============================================================================
// cpu_datapath_p
// ----------------------------------------------------------------------------
// Parametrised datapath for a 6502-style core. It holds the general register
// file, program counter (PCH:PCL), ALU output register (AOR), data input
// register (DIR) and the address buffer. It also builds the internal data bus
// (iDB), the special bus (SB) and the ADH/ADL address multiplexers. The
// control block drives every select and strobe. This block only routes values
// and stores them.
//
// Parameters
//   DW          data width; the address is 2*DW wide
//   NREG        number of general registers (2 or more)
//   SP_IDX      register index that acts as the stack pointer
//   STACK_PAGE  constant high address byte for stack accesses
//   VEC_BASE    low byte of the first interrupt vector
//
// Ports
//   clk, nRESET        clock; asynchronous active-low reset
//   clk_en             cycle qualifier
//   ready, rnw         bus stall (ready=0 stalls read cycles only); 1 = read
//   data_in            external data bus in
//   data_out, data_oe  external data bus out (= iDB); output enable (= ~rnw)
//   address            external address ({ADH,ADL} or the held buffer)
//   idb_sel            0 PCL, 1 PCH, 2 SB, 3 DIR, 4 REG[reg_rd], 5 psr_in,
//                      6 ADH, 7 zero
//   sb_sel             0 iDB, 1 REG[reg_rd], 2 AOR, 3 all-ones
//   reg_rd             register read index
//   reg_wr_en, reg_wr  write SB into REG[reg_wr]
//   adl_sel            0 PCL, 1 AOR, 2 REG[SP_IDX], 3 DIR, 4 vector,
//                      5 buffer_lo, 6-7 zero
//   adh_sel            0 PCH, 1 AOR, 2 DIR, 3 zero, 4 STACK_PAGE,
//                      5 all-ones, 6 buffer_hi, 7 zero
//   vec_sel            0 NMI, 1 RESET, 2/3 IRQ
//   addr_hold          drive address from the buffer
//   alub_sel           ALU B operand: 0 iDB, 1 ADL
//   psr_in, aor_in     status byte and ALU result from control/ALU
//   pc_en, pc_inc, aor_en, dir_en, buff_en   load strobes
//   idb, sb, alu_b     bus values exported to the ALU and control
//   page_cross         registered carry out of PCL into PCH
//
// Optional feature (macro CPU_DATAPATH_DEBUG_EN)
//   Adds dbg_sel[3:0] / dbg_val[2*DW-1:0], a combinational read port:
//   0..NREG-1 REG[n], 8 {PCH,PCL}, 9 AOR, 10 DIR, 11 buffer, else 0.
//   When the macro is undefined, the ports and the logic do not exist.
// ============================================================================
module cpu_datapath_p #(
    parameter int              DW         = 8,
    parameter int              NREG       = 4,
    parameter int              SP_IDX     = 3,
    parameter logic [DW-1:0]   STACK_PAGE = DW'(1),
    parameter logic [DW-1:0]   VEC_BASE   = {DW{1'b1}} - DW'(5),
    localparam int             RW         = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              clk_en,
    input  logic              ready,
    input  logic              rnw,
    input  logic [DW-1:0]     data_in,
    output logic [DW-1:0]     data_out,
    output logic              data_oe,
    output logic [2*DW-1:0]   address,
    input  logic [2:0]        idb_sel,
    input  logic [1:0]        sb_sel,
    input  logic [RW-1:0]     reg_rd,
    input  logic              reg_wr_en,
    input  logic [RW-1:0]     reg_wr,
    input  logic [2:0]        adl_sel,
    input  logic [2:0]        adh_sel,
    input  logic [1:0]        vec_sel,
    input  logic              addr_hold,
    input  logic              alub_sel,
    input  logic [DW-1:0]     psr_in,
    input  logic [DW-1:0]     aor_in,
    input  logic              pc_en,
    input  logic              pc_inc,
    input  logic              aor_en,
    input  logic              dir_en,
    input  logic              buff_en,
`ifdef CPU_DATAPATH_DEBUG_EN
    input  logic [3:0]        dbg_sel,
    output logic [2*DW-1:0]   dbg_val,
`endif
    output logic [DW-1:0]     idb,
    output logic [DW-1:0]     sb,
    output logic [DW-1:0]     alu_b,
    output logic              page_cross
);

    // ------------------------------------------------------------------------
    // Stall gating. A cycle takes effect only when clk_en is high and the
    // memory is ready. A write cycle (rnw=0) never waits for ready. A read
    // cycle (rnw=1) with ready=0 is frozen: every register holds, and DIR does
    // not capture the bus. Combinational outputs keep following the selects.
    // ------------------------------------------------------------------------
    logic w_en;
    assign w_en = clk_en & (ready | ~rnw);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DW-1:0] r_regs [NREG];
    logic [DW-1:0] r_pcl;
    logic [DW-1:0] r_pch;
    logic [DW-1:0] r_aor;
    logic [DW-1:0] r_dir;
    logic [DW-1:0] r_buf_lo;
    logic [DW-1:0] r_buf_hi;
    logic          r_page_cross;

    // ------------------------------------------------------------------------
    // Register file read ports. Each read scans the array, so an index at or
    // above NREG matches nothing and reads as zero. The stack pointer read
    // follows the same rule when SP_IDX is out of range.
    // ------------------------------------------------------------------------
    logic [DW-1:0] w_reg_rd_val;
    logic [DW-1:0] w_reg_sp_val;

    always_comb begin
        w_reg_rd_val = '0;
        w_reg_sp_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (reg_rd == RW'(i)) begin
                w_reg_rd_val = r_regs[i];
            end
            if (i == SP_IDX) begin
                w_reg_sp_val = r_regs[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Vector low byte. Vectors sit two bytes apart starting at VEC_BASE, and
    // vec_sel=3 aliases IRQ.
    // ------------------------------------------------------------------------
    logic [1:0]    w_vec_idx;
    logic [DW-1:0] w_vec_lo;

    assign w_vec_idx = (vec_sel == 2'd3) ? 2'd2 : vec_sel;
    assign w_vec_lo  = VEC_BASE + (DW'(w_vec_idx) << 1);

    // ------------------------------------------------------------------------
    // Address low / high multiplexers
    // ------------------------------------------------------------------------
    logic [DW-1:0] w_adl;
    logic [DW-1:0] w_adh;

    always_comb begin
        w_adl = '0;
        case (adl_sel)
            3'd0:    w_adl = r_pcl;
            3'd1:    w_adl = r_aor;
            3'd2:    w_adl = w_reg_sp_val;
            3'd3:    w_adl = r_dir;
            3'd4:    w_adl = w_vec_lo;
            3'd5:    w_adl = r_buf_lo;
            default: w_adl = '0;
        endcase
    end

    always_comb begin
        w_adh = '0;
        case (adh_sel)
            3'd0:    w_adh = r_pch;
            3'd1:    w_adh = r_aor;
            3'd2:    w_adh = r_dir;
            3'd3:    w_adh = '0;
            3'd4:    w_adh = STACK_PAGE;
            3'd5:    w_adh = '1;
            3'd6:    w_adh = r_buf_hi;
            default: w_adh = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Internal buses. iDB can take SB, and SB can take iDB. To keep this free
    // of a combinational loop, SB's own sources (w_sb_direct) are built first.
    // iDB only ever sees those sources. If both selects point at each other,
    // nothing drives the pair and they read as zero.
    // ------------------------------------------------------------------------
    logic [DW-1:0] w_sb_direct;
    logic [DW-1:0] w_idb;

    always_comb begin
        w_sb_direct = '0;
        case (sb_sel)
            2'd1:    w_sb_direct = w_reg_rd_val;
            2'd2:    w_sb_direct = r_aor;
            2'd3:    w_sb_direct = '1;
            default: w_sb_direct = '0;
        endcase
    end

    always_comb begin
        w_idb = '0;
        case (idb_sel)
            3'd0:    w_idb = r_pcl;
            3'd1:    w_idb = r_pch;
            3'd2:    w_idb = w_sb_direct;
            3'd3:    w_idb = r_dir;
            3'd4:    w_idb = w_reg_rd_val;
            3'd5:    w_idb = psr_in;
            3'd6:    w_idb = w_adh;
            default: w_idb = '0;
        endcase
    end

    assign idb      = w_idb;
    assign sb       = (sb_sel == 2'd0) ? w_idb : w_sb_direct;
    assign alu_b    = alub_sel ? w_adl : w_idb;
    assign data_out = w_idb;
    assign data_oe  = ~rnw;

    // ------------------------------------------------------------------------
    // Address output. The buffer path has zero latency. When buff_en and
    // addr_hold are both high, the old buffer is shown until the clock edge.
    // ------------------------------------------------------------------------
    assign address = addr_hold ? {r_buf_hi, r_buf_lo} : {w_adh, w_adl};

    // ------------------------------------------------------------------------
    // PC next value. The PC loads from the address buses, not from itself. An
    // increment is just ADL/ADH selecting PCL/PCH with pc_inc set. The carry
    // into PCH only exists when incrementing, and only when ADL is all ones.
    // ------------------------------------------------------------------------
    logic          w_carry;
    logic [DW-1:0] w_pcl_next;
    logic [DW-1:0] w_pch_next;

    assign w_carry    = pc_inc & (w_adl == {DW{1'b1}});
    assign w_pcl_next = w_adl + DW'(pc_inc);
    assign w_pch_next = w_adh + DW'(w_carry);

    // ------------------------------------------------------------------------
    // Register file write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_en && reg_wr_en) begin
            for (int i = 0; i < NREG; i++) begin
                if (reg_wr == RW'(i)) begin
                    r_regs[i] <= sb;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // PC, page_cross, AOR, DIR and buffer. page_cross is a one-cycle pulse.
    // It is set by a PC load that carries, and cleared by any other active
    // cycle. A stalled cycle holds it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_pcl        <= '0;
            r_pch        <= '0;
            r_page_cross <= 1'b0;
            r_aor        <= '0;
            r_dir        <= '0;
            r_buf_lo     <= '0;
            r_buf_hi     <= '0;
        end else if (w_en) begin
            if (pc_en) begin
                r_pcl        <= w_pcl_next;
                r_pch        <= w_pch_next;
                r_page_cross <= w_carry;
            end else begin
                r_page_cross <= 1'b0;
            end
            if (aor_en) begin
                r_aor <= aor_in;
            end
            if (dir_en) begin
                r_dir <= data_in;
            end
            if (buff_en) begin
                r_buf_lo <= w_adl;
                r_buf_hi <= w_adh;
            end
        end
    end

    assign page_cross = r_page_cross;

`ifdef CPU_DATAPATH_DEBUG_EN
    // ------------------------------------------------------------------------
    // Debug read port. Register indices are checked last, so they win if
    // NREG is large enough to overlap the fixed codes.
    // ------------------------------------------------------------------------
    always_comb begin
        dbg_val = '0;
        case (dbg_sel)
            4'd8:    dbg_val = {r_pch, r_pcl};
            4'd9:    dbg_val = {{DW{1'b0}}, r_aor};
            4'd10:   dbg_val = {{DW{1'b0}}, r_dir};
            4'd11:   dbg_val = {r_buf_hi, r_buf_lo};
            default: dbg_val = '0;
        endcase
        for (int i = 0; i < NREG; i++) begin
            if ((i < 16) && (dbg_sel == 4'(i))) begin
                dbg_val = {{DW{1'b0}}, r_regs[i]};
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_datapath_p.sv
// ============================================================================
// tb_cpu_datapath_p
// Directed bench for cpu_datapath_p. It drives a default 8-bit instance and a
// DW=16 / NREG=8 instance that share the clock, reset, selects and strobes.
// The wide instance is reset again just before its own checks, so the traffic
// it sees during the 8-bit steps does not matter.
// ============================================================================
module tb_cpu_datapath_p;

    // ---------------------------------------------------------------- signals
    logic        clk;
    logic        nRESET;
    logic        clk_en;
    logic        ready;
    logic        rnw;
    logic [2:0]  idb_sel;
    logic [1:0]  sb_sel;
    logic        reg_wr_en;
    logic [2:0]  adl_sel;
    logic [2:0]  adh_sel;
    logic [1:0]  vec_sel;
    logic        addr_hold;
    logic        alub_sel;
    logic        pc_en;
    logic        pc_inc;
    logic        aor_en;
    logic        dir_en;
    logic        buff_en;

    logic [7:0]  data_in;
    logic [7:0]  psr_in;
    logic [7:0]  aor_in;
    logic [1:0]  reg_rd;
    logic [1:0]  reg_wr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [15:0] address;
    logic [7:0]  idb;
    logic [7:0]  sb;
    logic [7:0]  alu_b;
    logic        page_cross;

    logic [15:0] data_in16;
    logic [15:0] psr_in16;
    logic [15:0] aor_in16;
    logic [2:0]  reg_rd16;
    logic [2:0]  reg_wr16;
    logic [15:0] data_out16;
    logic        data_oe16;
    logic [31:0] address16;
    logic [15:0] idb16;
    logic [15:0] sb16;
    logic [15:0] alu_b16;
    logic        page_cross16;

`ifdef CPU_DATAPATH_DEBUG_EN
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_val;
    logic [31:0] dbg_val16;
`endif

    int n_vec;
    int n_err;

    // ------------------------------------------------------------------- DUTs
    cpu_datapath_p u_dut (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .ready(ready), .rnw(rnw),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .address(address), .idb_sel(idb_sel), .sb_sel(sb_sel),
        .reg_rd(reg_rd), .reg_wr_en(reg_wr_en), .reg_wr(reg_wr),
        .adl_sel(adl_sel), .adh_sel(adh_sel), .vec_sel(vec_sel),
        .addr_hold(addr_hold), .alub_sel(alub_sel), .psr_in(psr_in),
        .aor_in(aor_in), .pc_en(pc_en), .pc_inc(pc_inc), .aor_en(aor_en),
        .dir_en(dir_en), .buff_en(buff_en),
`ifdef CPU_DATAPATH_DEBUG_EN
        .dbg_sel(dbg_sel), .dbg_val(dbg_val),
`endif
        .idb(idb), .sb(sb), .alu_b(alu_b), .page_cross(page_cross)
    );

    cpu_datapath_p #(.DW(16), .NREG(8)) u_dut16 (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .ready(ready), .rnw(rnw),
        .data_in(data_in16), .data_out(data_out16), .data_oe(data_oe16),
        .address(address16), .idb_sel(idb_sel), .sb_sel(sb_sel),
        .reg_rd(reg_rd16), .reg_wr_en(reg_wr_en), .reg_wr(reg_wr16),
        .adl_sel(adl_sel), .adh_sel(adh_sel), .vec_sel(vec_sel),
        .addr_hold(addr_hold), .alub_sel(alub_sel), .psr_in(psr_in16),
        .aor_in(aor_in16), .pc_en(pc_en), .pc_inc(pc_inc), .aor_en(aor_en),
        .dir_en(dir_en), .buff_en(buff_en),
`ifdef CPU_DATAPATH_DEBUG_EN
        .dbg_sel(dbg_sel), .dbg_val(dbg_val16),
`endif
        .idb(idb16), .sb(sb16), .alu_b(alu_b16), .page_cross(page_cross16)
    );

    // ---------------------------------------------------- clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------- driver tasks
    // Rising edges fall at 5, 15, 25, ... After tick, time is 1 past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clk_en = 1'b1; ready = 1'b1; rnw = 1'b1;
        idb_sel = 3'd0; sb_sel = 2'd0; reg_wr_en = 1'b0;
        adl_sel = 3'd0; adh_sel = 3'd0; vec_sel = 2'd0;
        addr_hold = 1'b0; alub_sel = 1'b0;
        pc_en = 1'b0; pc_inc = 1'b0; aor_en = 1'b0; dir_en = 1'b0; buff_en = 1'b0;
        data_in = 8'h00; psr_in = 8'h00; aor_in = 8'h00; reg_rd = 2'd0; reg_wr = 2'd0;
        data_in16 = 16'h0; psr_in16 = 16'h0; aor_in16 = 16'h0;
        reg_rd16 = 3'd0; reg_wr16 = 3'd0;
`ifdef CPU_DATAPATH_DEBUG_EN
        dbg_sel = 4'd0;
`endif
    endtask

    // ------------------------------------------------------- comparison point
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------- directed steps
    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        nRESET = 1'b1;
        #2 nRESET = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_address", address, 32'h0000);
        check("rst_page_cross", page_cross, 32'h0);
        check("rst_data_oe", data_oe, 32'h0);
        check("rst_idb_pcl", idb, 32'h00);
        sb_sel = 2'd2;
        #1 check("rst_sb_aor", sb, 32'h00);
        nRESET = 1'b1;

        // Register file: a same-cycle read returns the old value
        sb_sel = 2'd3; reg_wr_en = 1'b1; reg_wr = 2'd3; idb_sel = 3'd4; reg_rd = 2'd3;
        #1 check("reg_read_old", idb, 32'h00);
        check("sb_ones", sb, 32'hFF);
        tick();
        check("reg_read_new", idb, 32'hFF);
        idb_sel = 3'd5; psr_in = 8'hFD; sb_sel = 2'd0;
        #1 check("sb_from_idb_psr", sb, 32'hFD);
        check("data_out_idb", data_out, 32'hFD);
        tick();
        reg_wr_en = 1'b0; idb_sel = 3'd4;
        #1 check("reg3_fd", idb, 32'hFD);

        // Stack and vector addressing
        adl_sel = 3'd2; adh_sel = 3'd4;
        #1 check("stack_addr", address, 32'h01FD);
        adl_sel = 3'd4; adh_sel = 3'd5; vec_sel = 2'd2;
        #1 check("vec_irq", address, 32'hFFFE);
        vec_sel = 2'd3;
        #1 check("vec_irq_alias", address, 32'hFFFE);
        vec_sel = 2'd1; alub_sel = 1'b1;
        #1 check("vec_reset", address, 32'hFFFC);
        check("alu_b_adl", alu_b, 32'hFC);
        vec_sel = 2'd0; alub_sel = 1'b0;
        #1 check("vec_nmi", address, 32'hFFFA);

        // PC page cross: ADL=FF (DIR), ADH=12 (AOR)
        aor_in = 8'h12; aor_en = 1'b1; data_in = 8'hFF; dir_en = 1'b1;
        tick();
        aor_en = 1'b0; dir_en = 1'b0; adl_sel = 3'd3; adh_sel = 3'd1;
        #1 check("pc_src_addr", address, 32'h12FF);
        pc_en = 1'b1; pc_inc = 1'b1;
        tick();
        pc_en = 1'b0; pc_inc = 1'b0; adl_sel = 3'd0; adh_sel = 3'd0;
        #1 check("pc_cross_addr", address, 32'h1300);
        check("pc_cross_flag", page_cross, 32'h1);
        tick();
        check("pc_cross_clear", page_cross, 32'h0);
        check("pc_hold", address, 32'h1300);
        pc_en = 1'b1; pc_inc = 1'b1;
        tick();
        pc_en = 1'b0; pc_inc = 1'b0;
        #1 check("pc_inc_plain", address, 32'h1301);
        check("pc_inc_no_cross", page_cross, 32'h0);

        // PCH wrap: ADH=FF, ADL=FF
        aor_in = 8'hFF; aor_en = 1'b1;
        tick();
        aor_en = 1'b0; adl_sel = 3'd3; adh_sel = 3'd1; pc_en = 1'b1; pc_inc = 1'b1;
        tick();
        pc_en = 1'b0; pc_inc = 1'b0; adl_sel = 3'd0; adh_sel = 3'd0;
        #1 check("pch_wrap_addr", address, 32'h0000);
        check("pch_wrap_flag", page_cross, 32'h1);

        // Read stall: DIR, AOR and page_cross all hold
        rnw = 1'b1; ready = 1'b0; dir_en = 1'b1; data_in = 8'h5A;
        aor_en = 1'b1; aor_in = 8'h77; idb_sel = 3'd3; sb_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_dir", idb, 32'hFF);
        end
        check("stall_aor", sb, 32'hFF);
        check("stall_page_cross", page_cross, 32'h1);
        ready = 1'b1;
        tick();
        check("unstall_dir", idb, 32'h5A);
        check("unstall_aor", sb, 32'h77);
        check("unstall_pc_clear", page_cross, 32'h0);
        aor_en = 1'b0; rnw = 1'b0; ready = 1'b0; data_in = 8'hA5;
        #1 check("write_data_oe", data_oe, 32'h1);
        tick();
        check("write_not_stalled", idb, 32'hA5);
        clk_en = 1'b0; rnw = 1'b1; ready = 1'b1; data_in = 8'h33;
        tick();
        check("clk_en_low_hold", idb, 32'hA5);
        clk_en = 1'b1; dir_en = 1'b0;

        // Address buffer hold
        aor_in = 8'h34; aor_en = 1'b1; data_in = 8'h56; dir_en = 1'b1;
        tick();
        aor_en = 1'b0; dir_en = 1'b0; adl_sel = 3'd3; adh_sel = 3'd1; buff_en = 1'b1;
        #1 check("buf_src_addr", address, 32'h3456);
        tick();
        buff_en = 1'b0; addr_hold = 1'b1; adl_sel = 3'd4; vec_sel = 2'd2; adh_sel = 3'd5;
        #1 check("buf_hold", address, 32'h3456);
        tick();
        check("buf_hold_clk", address, 32'h3456);
        buff_en = 1'b1;
        #1 check("buf_same_cycle_old", address, 32'h3456);
        tick();
        buff_en = 1'b0;
        #1 check("buf_new_next", address, 32'hFFFE);
        addr_hold = 1'b0; adl_sel = 3'd5; adh_sel = 3'd6;
        #1 check("buf_via_mux", address, 32'hFFFE);

        // Asynchronous reset in the middle of a cycle
        data_in = 8'hFF; dir_en = 1'b1;
        tick();
        dir_en = 1'b0; adl_sel = 3'd3; adh_sel = 3'd1; pc_en = 1'b1; pc_inc = 1'b1;
        tick();
        pc_en = 1'b0; pc_inc = 1'b0; adl_sel = 3'd0; adh_sel = 3'd0; sb_sel = 2'd2;
        #1 check("pre_rst_addr", address, 32'h3500);
        check("pre_rst_flag", page_cross, 32'h1);
        check("pre_rst_aor", sb, 32'h34);
        #2 nRESET = 1'b0;
        #1 check("async_rst_addr", address, 32'h0000);
        check("async_rst_flag", page_cross, 32'h0);
        check("async_rst_aor", sb, 32'h00);
        #2 nRESET = 1'b1;

        // Wide build: DW=16, NREG=8
        idb_sel = 3'd5; sb_sel = 2'd0; reg_wr_en = 1'b1; reg_wr16 = 3'd7;
        psr_in16 = 16'hBEEF;
        #1 check("w16_sb_write", sb16, 32'hBEEF);
        check("w16_data_out", data_out16, 32'hBEEF);
        check("w16_alu_b", alu_b16, 32'hBEEF);
        check("w16_data_oe", data_oe16, 32'h0);
        tick();
        reg_wr_en = 1'b0; sb_sel = 2'd1; reg_rd16 = 3'd7;
        #1 check("w16_reg7", sb16, 32'hBEEF);
        reg_rd16 = 3'd6;
        #1 check("w16_reg6_zero", sb16, 32'h0000);
        idb_sel = 3'd4; reg_rd16 = 3'd7;
        #1 check("w16_idb_reg7", idb16, 32'hBEEF);
        aor_in16 = 16'hFFFF; aor_en = 1'b1;
        tick();
        aor_en = 1'b0; adl_sel = 3'd1; adh_sel = 3'd5;
        #1 check("w16_pc_src", address16, 32'hFFFF_FFFF);
        pc_en = 1'b1; pc_inc = 1'b1;
        tick();
        pc_en = 1'b0; pc_inc = 1'b0; adl_sel = 3'd0; adh_sel = 3'd0;
        #1 check("w16_pc_wrap", address16, 32'h0000_0000);
        check("w16_pc_wrap_flag", page_cross16, 32'h1);

`ifdef CPU_DATAPATH_DEBUG_EN
        dbg_sel = 4'd7;
        #1 check("dbg_reg7", dbg_val16, 32'h0000_BEEF);
        dbg_sel = 4'd9;
        #1 check("dbg_aor", dbg_val16, 32'h0000_FFFF);
        dbg_sel = 4'd8;
        #1 check("dbg_pc", dbg_val16, 32'h0000_0000);
        dbg_sel = 4'd15;
        #1 check("dbg_other", dbg_val, 32'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_datapath_p.md
Name: cpu_datapath_p

Overview:
- Parametrised successor to the fixed 8-bit 6502 datapath.
- Holds the general register file, program counter, ALU output register (AOR), data input register (DIR) and address buffer, plus the internal bus (iDB), special bus (SB) and address-bus multiplexers.
- Width, register count, stack page and vector base are generic. Adds READY read-stall, PC page-cross detection and resettable address buffers.
- Sits between the external bus pins and the control/ALU blocks, which drive all of its selects.

Parameters:
- DW, 8, data width; address width is 2*DW.
- NREG, 4, general register count (minimum 2); index width RW = clog2(NREG).
- SP_IDX, 3, register index used as stack pointer.
- STACK_PAGE, 1, constant high address byte for stack accesses.
- VEC_BASE, all-ones minus 5 (8'hFA at DW=8), low byte of the first vector.

Ports:
- clk  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- clk_en  in  1  cycle qualifier
- ready  in  1  0 stalls read cycles
- rnw  in  1  1 = read, 0 = write
- data_in  in  DW  external data bus
- data_out  out  DW  equals iDB
- data_oe  out  1  equals ~rnw
- address  out  2*DW  external address
- idb_sel  in  3  0 PCL, 1 PCH, 2 SB, 3 DIR, 4 REG[reg_rd], 5 psr_in, 6 ADH, 7 zero
- sb_sel  in  2  0 iDB, 1 REG[reg_rd], 2 AOR, 3 all-ones
- reg_rd  in  RW  register read index
- reg_wr_en  in  1  write SB into REG[reg_wr]
- reg_wr  in  RW  register write index
- adl_sel  in  3  0 PCL, 1 AOR, 2 REG[SP_IDX], 3 DIR, 4 VEC_BASE+2*vec_sel, 5 buffer_lo, 6-7 zero
- adh_sel  in  3  0 PCH, 1 AOR, 2 DIR, 3 zero, 4 STACK_PAGE, 5 all-ones, 6 buffer_hi, 7 zero
- vec_sel  in  2  0 NMI, 1 RESET, 2 IRQ, 3 IRQ
- addr_hold  in  1  drive address from buffer instead of ADH/ADL
- alub_sel  in  1  0 iDB, 1 ADL
- psr_in  in  DW  status byte from control
- aor_in  in  DW  ALU result
- pc_en, pc_inc, aor_en, dir_en, buff_en  in  1 each  load strobes
- idb, sb, alu_b  out  DW  bus values to ALU/control
- page_cross  out  1  registered PC carry into PCH

Behaviour:
- Stall/enable: en = clk_en & (ready | ~rnw). All state updates require en. With en=0 every register holds; combinational outputs still follow the selects.
- Reset: asynchronous on nRESET low. All registers, PC, AOR, DIR, buffer_hi/lo and page_cross go to 0. Outputs then resolve combinationally from zeroed state.
- Register file:
  - Written at the clock edge when en & reg_wr_en; SB value is written.
  - Reads are combinational; a read of the register being written returns the old value.
  - Index >= NREG: writes are ignored, reads return 0.
- PC update (en & pc_en):
  - PCL <= ADL + pc_inc, modulo 2^DW.
  - PCH <= ADH + carry, where carry = pc_inc & (ADL == all-ones).
  - page_cross <= that carry.
  - page_cross clears on any en cycle without pc_en.
  - PCH wraps to 0 from all-ones with no flag beyond page_cross.
- AOR <= aor_in when en & aor_en.
- DIR <= data_in when en & dir_en. A stalled read does not capture.
- Buffer <= {ADH, ADL} when en & buff_en.
- address = addr_hold ? {buffer_hi, buffer_lo} : {ADH, ADL}. Combinational, zero latency.
- Simultaneous buff_en & addr_hold: address shows the old buffer; the new value is visible next cycle.
- All registers use one clock edge. No internal FSM beyond the stall gating; the control block sequences cycles.

Optional Feature:
- Macro: CPU_DATAPATH_DEBUG_EN.
- Defined: adds input dbg_sel[3:0] and output dbg_val[2*DW-1:0].
  - 0..NREG-1 select REG[n] zero-extended.
  - 8 selects {PCH, PCL}; 9 selects AOR; 10 selects DIR; 11 selects buffer.
  - Any other value returns 0. Fully combinational.
- Undefined: the ports are absent and no logic is generated.

Test Plan:
- Reset: nRESET low mid-cycle, asynchronous -> address=16'h0000, PC=0, page_cross=0 immediately, no clock needed.
- PC cross: ADL=8'hFF, ADH=8'h12, pc_en=1, pc_inc=1 -> next cycle PCL=8'h00, PCH=8'h13, page_cross=1; the following idle en cycle -> page_cross=0.
- Stall: rnw=1, ready=0, dir_en=1, data_in=8'h5A for 3 cycles -> DIR unchanged. ready=1 -> DIR=8'h5A next edge. Same with rnw=0, ready=0 -> writes proceed.
- Stack/vector: REG[3]=8'hFD, adl_sel=2, adh_sel=4 -> address=16'h01FD. adl_sel=4, vec_sel=2, adh_sel=5 -> address=16'hFFFE.
- Buffer hold: buff_en with {ADH,ADL}=16'h3456, then addr_hold=1 while ADH/ADL change -> address stays 16'h3456.
- Parametric: DW=16, NREG=8 build -> write REG[7]=16'hBEEF via SB and read it back on sb. PC wrap 32'hFFFF_FFFF+1 -> 32'h0000_0000 with page_cross=1.
